// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction queue with NOP bubbles and flush
// Ports: clk, resetn (async active-low); flush drops queued and incoming words;
//   in_valid/in_ready/in_ins/in_pc/in_adel from fetch; out_valid/out_ready/
//   out_ins/out_pc/out_adel to decode; count = occupied entries (0..DEPTH).
module if_id_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [31:0]      in_pc,
    input  logic             in_adel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ins,
    output logic [31:0]      out_pc,
    output logic             out_adel,
    output logic [PTR_W:0]   count
);
    logic [31:0]      ins_q [DEPTH];
    logic [31:0]      pc_q  [DEPTH];
    logic             adel_q[DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;
    always_comb begin
        in_ready  = (count != (PTR_W+1)'(DEPTH)) && !flush;
        out_valid = count != '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // a faulting fetch decodes as a NOP; the PC still goes out for EPC
        out_adel  = out_valid ? adel_q[rd_ptr] : 1'b0;
        out_ins   = (out_valid && !adel_q[rd_ptr]) ? ins_q[rd_ptr] : 32'h0;
        out_pc    = out_valid ? pc_q[rd_ptr] : 32'h0;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) begin
            ins_q[wr_ptr]  <= in_ins;
            pc_q[wr_ptr]   <= in_pc;
            adel_q[wr_ptr] <= in_adel;
        end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue
module tb_if_id_queue;
    logic        clk = 0, resetn = 0, flush = 0, in_valid = 0, in_adel = 0, out_ready = 0;
    logic [31:0] in_ins = 0, in_pc = 0;
    logic        in_ready, out_valid, out_adel;
    logic [31:0] out_ins, out_pc;
    logic [2:0]  count;
    int          total = 0, bad = 0, acc = 0;
    if_id_queue #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc), .in_adel(in_adel),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
        .out_adel(out_adel), .count(count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic adel);
        in_valid = 1;
        in_ins   = ins;
        in_pc    = pc;
        in_adel  = adel;
    endtask
    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ins", out_ins, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_adel", 32'(out_adel), 0);
        repeat (2) @(negedge clk);
        resetn = 1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 6; k++) begin
            offer(32'h24080001 + k, 32'hBFC00000 + 32'(4 * k), 0);
            #1 if (in_ready) acc++;
            @(negedge clk);
            chk("fill_count", 32'(count), k < 3 ? 32'(k + 1) : 4);
            chk("fill_head_ins", out_ins, 32'h24080001);
            chk("fill_head_pc", out_pc, 32'hBFC00000);
        end
        chk("fill_accepted", 32'(acc), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        offer(32'h11111111, 32'h00000100, 0);
        out_ready = 1;
        @(negedge clk);
        chk("fullpop_count", 32'(count), 3);
        chk("fullpop_ins", out_ins, 32'h24080002);
        chk("fullpop_pc", out_pc, 32'hBFC00004);
        chk("fullpop_in_ready", 32'(in_ready), 1);
        out_ready = 0;
        @(negedge clk);
        chk("refill_count", 32'(count), 4);
        chk("refill_ins", out_ins, 32'h24080002);
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        chk("pre_flush_count", 32'(count), 3);
        offer(32'hDEADBEEF, 32'h00000200, 0);
        flush = 1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_old_head", out_ins, 32'h24080003);
        @(negedge clk);
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ins", out_ins, 0);
        chk("flush_pc", out_pc, 0);
        flush    = 0;
        in_valid = 0;
        @(negedge clk);
        chk("post_flush_valid", 32'(out_valid), 0);
        chk("post_flush_ins", out_ins, 0);
        for (int k = 0; k < 10; k++) begin
            offer(32'h30000000 + k, 32'h00001000 + 32'(4 * k), 0);
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_count", 32'(count), 1);
            chk("stream_ins", out_ins, 32'h30000000 + k);
            chk("stream_pc", out_pc, 32'h00001000 + 32'(4 * k));
        end
        in_valid = 0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_ins", out_ins, 0);
        out_ready = 0;
        offer(32'hFFFFFFFF, 32'hBFC00002, 1);
        @(negedge clk);
        in_valid = 0;
        in_adel  = 0;
        repeat (2) begin
            chk("adel_valid", 32'(out_valid), 1);
            chk("adel_flag", 32'(out_adel), 1);
            chk("adel_ins", out_ins, 0);
            chk("adel_pc", out_pc, 32'hBFC00002);
            @(negedge clk);
        end
        offer(32'h24090000, 32'hBFC00008, 0);
        out_ready = 1;
        @(negedge clk);
        chk("after_adel_flag", 32'(out_adel), 0);
        chk("after_adel_ins", out_ins, 32'h24090000);
        chk("after_adel_count", 32'(count), 1);
        offer(32'h240A0000, 32'hBFC0000C, 0);
        out_ready = 0;
        @(negedge clk);
        chk("pre_reset_count", 32'(count), 2);
        #2 resetn = 0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_count", 32'(count), 0);
        chk("async_ins", out_ins, 0);
        chk("async_pc", out_pc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
